hw_accel_sobel_core: RTL and testbench

//  Streaming pixel core between the DMA input FIFO (read side) and the DMA output FIFO (write side) of the HW accelerator.
//  Per pixel: RGB888 -> 8-bit gray, 3x3 Sobel over two line buffers, |Gx|+|Gy| compared to a threshold, binary pixel out.
//  No backpressure. The pipeline advances on input valid, and on self-generated flush ticks at frame end.

---
 rtl/hw_accel_sobel_core.sv | 225 ++++++++++++++++++++++
 tb/tb_hw_accel_sobel_core.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hw_accel_sobel_core.sv
`default_nettype none
// ============================================================================
// Module   : hw_accel_sobel_core
// Purpose  : Streaming RGB888 -> gray -> 3x3 Sobel -> threshold, binary pixel out.
// Revision : 1.0  initial release
// ============================================================================
module hw_accel_sobel_core #(
    parameter int DATA_WIDTH   = 32,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  pixel_in_valid,
    input  logic [31:0]           sobel_thresh,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  pixel_out_valid,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_overrun
);
    localparam int c_NPIX = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int c_NADV = c_NPIX + FRAME_WIDTH + 1;
    localparam int c_CW   = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int c_RW   = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int c_NW   = $clog2(c_NADV + 1);
    localparam int c_TW   = $clog2(FRAME_WIDTH + 1);
    localparam logic [c_CW-1:0] c_COL_LAST  = c_CW'(FRAME_WIDTH - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST  = c_RW'(FRAME_HEIGHT - 1);
    localparam logic [c_NW-1:0] c_NPIX_M1   = c_NW'(c_NPIX - 1);
    localparam logic [c_NW-1:0] c_FIRST_OUT = c_NW'(FRAME_WIDTH + 1);
    localparam logic [c_NW-1:0] c_NADV_V    = c_NW'(c_NADV);
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(FRAME_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_NW-1:0] r_in_cnt, w_in_cnt_nxt;
    logic [c_TW-1:0] r_tick_cnt, w_tick_cnt_nxt;
    logic [1:0]      r_drain_cnt, w_drain_cnt_nxt;
    logic            w_accept, w_adv, w_to_idle;
    logic [15:0]     w_gray_sum;
    logic            w_unused;
    logic            r_v1;
    logic [7:0]      r_gray;

    assign w_accept   = pixel_in_valid && (r_state == ST_IDLE || r_state == ST_RUN);
    assign w_adv      = w_accept || (r_state == ST_FLUSH);
    assign busy       = (r_state != ST_IDLE);
    assign w_gray_sum = 16'd77  * {8'd0, pixel_in[23:16]}
                      + 16'd150 * {8'd0, pixel_in[15:8]}
                      + 16'd29  * {8'd0, pixel_in[7:0]};
    assign w_unused   = ^pixel_in[DATA_WIDTH-1:24];

    always_comb begin
        w_state_nxt     = r_state;
        w_in_cnt_nxt    = r_in_cnt;
        w_tick_cnt_nxt  = r_tick_cnt;
        w_drain_cnt_nxt = r_drain_cnt;
        w_to_idle       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = ST_RUN;
                    w_in_cnt_nxt = c_NW'(1);
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    w_in_cnt_nxt = r_in_cnt + 1'b1;
                    if (r_in_cnt == c_NPIX_M1) w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                if (r_tick_cnt == c_TICK_LAST) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_drain_cnt_nxt = r_drain_cnt + 1'b1;
                if (r_drain_cnt == 2'd3) begin
                    w_state_nxt     = ST_IDLE;
                    w_to_idle       = 1'b1;
                    w_in_cnt_nxt    = '0;
                    w_tick_cnt_nxt  = '0;
                    w_drain_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Stage 1: control state and gray register (flush ticks inject black)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_cnt    <= '0;
            r_tick_cnt  <= '0;
            r_drain_cnt <= '0;
            err_overrun <= 1'b0;
            r_v1        <= 1'b0;
            r_gray      <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_cnt    <= w_in_cnt_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            if (pixel_in_valid && (r_state == ST_FLUSH || r_state == ST_DRAIN))
                err_overrun <= 1'b1;
            r_v1 <= w_adv;
            if (w_adv) r_gray <= w_accept ? w_gray_sum[15:8] : 8'd0;
        end
    end

    // Stage 2: line buffers and 3x3 window; row 0 is the oldest line
    logic [7:0]      r_lb0 [FRAME_WIDTH];
    logic [7:0]      r_lb1 [FRAME_WIDTH];
    logic [7:0]      r_p00, r_p01, r_p02, r_p10, r_p11, r_p12, r_p20, r_p21, r_p22;
    logic [c_CW-1:0] r_col, r_cx;
    logic [c_RW-1:0] r_cy;
    logic [c_NW-1:0] r_adv_cnt;
    logic            w_emit, r_v2, r_bord2, r_last2;

    assign w_emit = r_v1 && (r_adv_cnt >= c_FIRST_OUT);

    always_ff @(posedge clk) begin
        if (r_v1) begin
            r_lb0[r_col] <= r_gray;
            r_lb1[r_col] <= r_lb0[r_col];
            r_p00 <= r_p01;  r_p01 <= r_p02;  r_p02 <= r_lb1[r_col];
            r_p10 <= r_p11;  r_p11 <= r_p12;  r_p12 <= r_lb0[r_col];
            r_p20 <= r_p21;  r_p21 <= r_p22;  r_p22 <= r_gray;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col     <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
            r_adv_cnt <= '0;
            r_v2      <= 1'b0;
            r_bord2   <= 1'b0;
            r_last2   <= 1'b0;
        end else begin
            r_v2    <= w_emit;
            r_bord2 <= (r_cx == '0) || (r_cx == c_COL_LAST) || (r_cy == '0) || (r_cy == c_ROW_LAST);
            r_last2 <= (r_cx == c_COL_LAST) && (r_cy == c_ROW_LAST);
            if (w_to_idle) begin
                r_col     <= '0;
                r_cx      <= '0;
                r_cy      <= '0;
                r_adv_cnt <= '0;
            end else if (r_v1) begin
                r_col <= (r_col == c_COL_LAST) ? '0 : r_col + 1'b1;
                if (r_adv_cnt != c_NADV_V) r_adv_cnt <= r_adv_cnt + 1'b1;
                if (w_emit) begin
                    if (r_cx == c_COL_LAST) begin
                        r_cx <= '0;
                        r_cy <= (r_cy == c_ROW_LAST) ? '0 : r_cy + 1'b1;
                    end else begin
                        r_cx <= r_cx + 1'b1;
                    end
                end
            end
        end
    end

    // Stage 3: gradients, kept as 11-bit two's complement
    logic [9:0]  w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic [10:0] r_gx, r_gy;
    logic        r_v3, r_bord3, r_last3;

    assign w_gx_pos = {2'b00, r_p02} + {1'b0, r_p12, 1'b0} + {2'b00, r_p22};
    assign w_gx_neg = {2'b00, r_p00} + {1'b0, r_p10, 1'b0} + {2'b00, r_p20};
    assign w_gy_pos = {2'b00, r_p20} + {1'b0, r_p21, 1'b0} + {2'b00, r_p22};
    assign w_gy_neg = {2'b00, r_p00} + {1'b0, r_p01, 1'b0} + {2'b00, r_p02};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gx    <= '0;
            r_gy    <= '0;
            r_v3    <= 1'b0;
            r_bord3 <= 1'b0;
            r_last3 <= 1'b0;
        end else begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_gx    <= {1'b0, w_gx_pos} - {1'b0, w_gx_neg};
                r_gy    <= {1'b0, w_gy_pos} - {1'b0, w_gy_neg};
                r_bord3 <= r_bord2;
                r_last3 <= r_last2;
            end
        end
    end

    // Stage 4: magnitude, threshold and border forcing
    logic [10:0] w_abs_gx, w_abs_gy, w_mag, w_thresh;
    logic        w_edge;

    assign w_abs_gx = r_gx[10] ? (~r_gx + 11'd1) : r_gx;
    assign w_abs_gy = r_gy[10] ? (~r_gy + 11'd1) : r_gy;
    assign w_mag    = w_abs_gx + w_abs_gy;
    assign w_thresh = (|sobel_thresh[31:11]) ? 11'h7FF : sobel_thresh[10:0];
    assign w_edge   = !r_bord3 && (w_mag >= w_thresh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_out       <= '0;
            pixel_out_valid <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            pixel_out_valid <= r_v3;
            frame_done      <= r_v3 && r_last3;
            if (r_v3) pixel_out <= {{(DATA_WIDTH-24){1'b0}}, {24{w_edge}}};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hw_accel_sobel_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_hw_accel_sobel_core
// Purpose  : Directed self-checking bench for hw_accel_sobel_core (8x6 frames).
// Revision : 1.0  initial release
// ============================================================================
module tb_hw_accel_sobel_core;
    localparam int c_W = 8;
    localparam int c_H = 6;
    localparam int c_N = c_W * c_H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pixel_in = 32'h0;
    logic        pixel_in_valid = 1'b0;
    logic [31:0] sobel_thresh = 32'd100;
    logic [31:0] pixel_out;
    logic        pixel_out_valid, busy, frame_done, err_overrun;

    hw_accel_sobel_core #(
        .DATA_WIDTH   (32),
        .FRAME_WIDTH  (c_W),
        .FRAME_HEIGHT (c_H)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .pixel_in        (pixel_in),
        .pixel_in_valid  (pixel_in_valid),
        .sobel_thresh    (sobel_thresh),
        .pixel_out       (pixel_out),
        .pixel_out_valid (pixel_out_valid),
        .busy            (busy),
        .frame_done      (frame_done),
        .err_overrun     (err_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          errs = 0;
    int          chks = 0;
    logic [23:0] img [c_N];
    int          in_cyc [c_N];
    logic [31:0] saved [c_N];
    logic [31:0] out_q [$];
    int          out_cyc [$];
    int          fd_cnt = 0;
    int          fd_idx = -1;
    logic        fd_busy = 1'b0;
    logic        busy_after = 1'b0;
    int          fd_frame = 0;
    bit          tmo;

    always @(negedge clk) begin
        if (pixel_out_valid) begin
            out_q.push_back(pixel_out);
            out_cyc.push_back(cyc);
        end
        if (frame_done) begin
            fd_cnt++;
            fd_idx  = out_q.size() - 1;
            fd_busy = busy;
        end
    end

    function automatic int gray_of(input logic [23:0] p);
        return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) >> 8;
    endfunction

    function automatic int g_at(input int x, input int y);
        return gray_of(img[y * c_W + x]);
    endfunction

    // Plain 2-D reference over the stored image; interior windows never wrap.
    function automatic logic [31:0] model_pix(input int cx, input int cy, input logic [31:0] thr);
        int gx, gy, mag, t;
        if (cx == 0 || cx == c_W - 1 || cy == 0 || cy == c_H - 1) return 32'h0;
        gx = (g_at(cx+1, cy-1) + 2 * g_at(cx+1, cy) + g_at(cx+1, cy+1))
           - (g_at(cx-1, cy-1) + 2 * g_at(cx-1, cy) + g_at(cx-1, cy+1));
        gy = (g_at(cx-1, cy+1) + 2 * g_at(cx, cy+1) + g_at(cx+1, cy+1))
           - (g_at(cx-1, cy-1) + 2 * g_at(cx, cy-1) + g_at(cx+1, cy-1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        t   = (thr > 32'd2047) ? 2047 : int'(thr);
        return (mag >= t) ? 32'h00FF_FFFF : 32'h0;
    endfunction

    function automatic logic [31:0] got_at(input int i);
        return (i < out_q.size()) ? out_q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic drive_pix(input logic [23:0] p);
        @(posedge clk); #1;
        pixel_in       = {8'hA5, p};
        pixel_in_valid = 1'b1;
    endtask

    task automatic drive_idle();
        @(posedge clk); #1;
        pixel_in       = 32'h0;
        pixel_in_valid = 1'b0;
    endtask

    task automatic run_frame(input bit gapped, input int extra, output bit timed_out);
        int start, n;
        out_q.delete();
        out_cyc.delete();
        start = fd_cnt;
        for (int i = 0; i < c_N; i++) begin
            if (gapped)
                for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) drive_idle();
            drive_pix(img[i]);
            in_cyc[i] = cyc;
        end
        for (int e = 0; e < extra; e++) drive_pix(24'h5A5A5A);
        drive_idle();
        n = 0;
        while (fd_cnt == start && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        timed_out = (fd_cnt == start);
        @(negedge clk); #1;
        busy_after = busy;
        repeat (6) @(negedge clk);
        #1;
        fd_frame = fd_cnt - start;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        chks++; if (pixel_out !== 32'h0) begin errs++; $display("FAIL reset_pixel_out: got %h want 00000000", pixel_out); end
        chks++; if (pixel_out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", pixel_out_valid); end
        chks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        chks++; if (frame_done !== 1'b0) begin errs++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        chks++; if (err_overrun !== 1'b0) begin errs++; $display("FAIL reset_err: got %b want 0", err_overrun); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chks++; if (pixel_out_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL post_reset_idle: valid=%b busy=%b want 0/0", pixel_out_valid, busy); end
    endtask

    task automatic test_flat();
        for (int i = 0; i < c_N; i++) img[i] = 24'h808080;
        sobel_thresh = 32'd100;
        run_frame(1'b0, 0, tmo);
        chks++; if (tmo) begin errs++; $display("FAIL flat_timeout: no frame_done, outputs=%0d want 48", out_q.size()); end
        chks++; if (out_q.size() != c_N) begin errs++; $display("FAIL flat_count: got %0d want %0d", out_q.size(), c_N); end
        for (int i = 0; i < c_N; i++) begin
            chks++; if (got_at(i) !== 32'h0) begin errs++; $display("FAIL flat_pix[%0d]: got %h want 00000000", i, got_at(i)); end
        end
        chks++; if (fd_frame != 1) begin errs++; $display("FAIL flat_fd_count: got %0d want 1", fd_frame); end
        chks++; if (fd_idx != c_N - 1) begin errs++; $display("FAIL flat_fd_index: got %0d want %0d", fd_idx, c_N - 1); end
        chks++; if (fd_busy !== 1'b1) begin errs++; $display("FAIL flat_busy_at_done: got %b want 1", fd_busy); end
        chks++; if (busy_after !== 1'b0) begin errs++; $display("FAIL flat_busy_after: got %b want 0", busy_after); end
    endtask

    // Thresholds 100 and 1020 pass the |Gx|=1020 edge; 1021 and a saturating value do not.
    task automatic test_vertical_edge();
        logic [31:0] thr_tab [4];
        bit          on_tab [4];
        logic [31:0] want;
        int          cx, cy;
        thr_tab[0] = 32'd100;    on_tab[0] = 1'b1;
        thr_tab[1] = 32'd1020;   on_tab[1] = 1'b1;
        thr_tab[2] = 32'd1021;   on_tab[2] = 1'b0;
        thr_tab[3] = 32'h10000;  on_tab[3] = 1'b0;
        for (int i = 0; i < c_N; i++) img[i] = ((i % c_W) < 4) ? 24'h000000 : 24'hFFFFFF;
        for (int t = 0; t < 4; t++) begin
            sobel_thresh = thr_tab[t];
            run_frame(1'b0, 0, tmo);
            chks++; if (tmo || out_q.size() != c_N) begin errs++; $display("FAIL edge_count thr=%0d: got %0d want %0d", thr_tab[t], out_q.size(), c_N); end
            for (int i = 0; i < c_N; i++) begin
                cx = i % c_W;
                cy = i / c_W;
                want = (on_tab[t] && cy >= 1 && cy <= 4 && (cx == 3 || cx == 4)) ? 32'h00FF_FFFF : 32'h0;
                chks++; if (got_at(i) !== want) begin errs++; $display("FAIL edge_pix thr=%0d (%0d,%0d): got %h want %h", thr_tab[t], cx, cy, got_at(i), want); end
            end
        end
    endtask

    task automatic test_thresh_zero();
        logic [31:0] want;
        int          cx, cy;
        for (int i = 0; i < c_N; i++) img[i] = 24'($urandom);
        sobel_thresh = 32'd0;
        run_frame(1'b0, 0, tmo);
        chks++; if (tmo || out_q.size() != c_N) begin errs++; $display("FAIL thr0_count: got %0d want %0d", out_q.size(), c_N); end
        for (int i = 0; i < c_N; i++) begin
            cx = i % c_W;
            cy = i / c_W;
            want = (cx >= 1 && cx <= 6 && cy >= 1 && cy <= 4) ? 32'h00FF_FFFF : 32'h0;
            chks++; if (got_at(i) !== want) begin errs++; $display("FAIL thr0_pix (%0d,%0d): got %h want %h", cx, cy, got_at(i), want); end
        end
    endtask

    task automatic test_gapped();
        int a, want_cyc, got_cyc;
        for (int i = 0; i < c_N; i++) img[i] = ((i % c_W) + (i / c_W) > 5) ? 24'($urandom) | 24'h808080 : 24'($urandom) & 24'h1F1F1F;
        sobel_thresh = 32'd100;
        run_frame(1'b0, 0, tmo);
        chks++; if (tmo || out_q.size() != c_N) begin errs++; $display("FAIL ungapped_count: got %0d want %0d", out_q.size(), c_N); end
        for (int i = 0; i < c_N; i++) begin
            saved[i] = got_at(i);
            chks++; if (got_at(i) !== model_pix(i % c_W, i / c_W, sobel_thresh)) begin errs++; $display("FAIL ungapped_pix[%0d]: got %h want %h", i, got_at(i), model_pix(i % c_W, i / c_W, sobel_thresh)); end
        end
        run_frame(1'b1, 0, tmo);
        chks++; if (tmo || out_q.size() != c_N) begin errs++; $display("FAIL gapped_count: got %0d want %0d", out_q.size(), c_N); end
        for (int i = 0; i < c_N; i++) begin
            chks++; if (got_at(i) !== saved[i]) begin errs++; $display("FAIL gapped_pix[%0d]: got %h want %h", i, got_at(i), saved[i]); end
            a        = i + c_W + 1;
            want_cyc = (a < c_N) ? in_cyc[a] + 4 : in_cyc[c_N-1] + (a - (c_N - 1)) + 4;
            got_cyc  = (i < out_cyc.size()) ? out_cyc[i] : -1;
            chks++; if (got_cyc != want_cyc) begin errs++; $display("FAIL gapped_delay[%0d]: got cycle %0d want %0d", i, got_cyc, want_cyc); end
        end
    endtask

    task automatic test_overrun();
        logic [31:0] want;
        int          cx, cy;
        for (int i = 0; i < c_N; i++) img[i] = ((i % c_W) < 4) ? 24'h000000 : 24'hFFFFFF;
        sobel_thresh = 32'd100;
        run_frame(1'b0, 2, tmo);
        chks++; if (err_overrun !== 1'b1) begin errs++; $display("FAIL overrun_flag: got %b want 1", err_overrun); end
        chks++; if (tmo || out_q.size() != c_N) begin errs++; $display("FAIL overrun_count: got %0d want %0d", out_q.size(), c_N); end
        for (int i = 0; i < c_N; i++) begin
            cx = i % c_W;
            cy = i / c_W;
            want = (cy >= 1 && cy <= 4 && (cx == 3 || cx == 4)) ? 32'h00FF_FFFF : 32'h0;
            chks++; if (got_at(i) !== want) begin errs++; $display("FAIL overrun_pix (%0d,%0d): got %h want %h", cx, cy, got_at(i), want); end
        end
        for (int i = 0; i < c_N; i++) img[i] = 24'($urandom);
        run_frame(1'b0, 0, tmo);
        chks++; if (tmo || out_q.size() != c_N) begin errs++; $display("FAIL next_frame_count: got %0d want %0d", out_q.size(), c_N); end
        for (int i = 0; i < c_N; i++) begin
            chks++; if (got_at(i) !== model_pix(i % c_W, i / c_W, sobel_thresh)) begin errs++; $display("FAIL next_frame_pix[%0d]: got %h want %h", i, got_at(i), model_pix(i % c_W, i / c_W, sobel_thresh)); end
        end
        chks++; if (err_overrun !== 1'b1) begin errs++; $display("FAIL overrun_sticky: got %b want 1", err_overrun); end
    endtask

    task automatic test_reset_midframe();
        int fd_before;
        for (int i = 0; i < c_N; i++) img[i] = 24'($urandom);
        sobel_thresh = 32'd100;
        for (int i = 0; i < 20; i++) drive_pix(img[i]);
        @(posedge clk); #1;
        rst            = 1'b1;
        pixel_in_valid = 1'b0;
        out_q.delete();
        out_cyc.delete();
        fd_before = fd_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        chks++; if (out_q.size() != 0) begin errs++; $display("FAIL midrst_outputs: got %0d want 0", out_q.size()); end
        chks++; if (busy !== 1'b0) begin errs++; $display("FAIL midrst_busy: got %b want 0", busy); end
        chks++; if (err_overrun !== 1'b0) begin errs++; $display("FAIL midrst_err: got %b want 0", err_overrun); end
        chks++; if (fd_cnt != fd_before) begin errs++; $display("FAIL midrst_frame_done: got %0d pulses want 0", fd_cnt - fd_before); end
        run_frame(1'b0, 0, tmo);
        chks++; if (tmo || out_q.size() != c_N) begin errs++; $display("FAIL fresh_count: got %0d want %0d", out_q.size(), c_N); end
        chks++; if (fd_frame != 1 || fd_idx != c_N - 1) begin errs++; $display("FAIL fresh_fd: got %0d pulses at %0d want 1 at %0d", fd_frame, fd_idx, c_N - 1); end
        for (int i = 0; i < c_N; i++) begin
            chks++; if (got_at(i) !== model_pix(i % c_W, i / c_W, sobel_thresh)) begin errs++; $display("FAIL fresh_pix[%0d]: got %h want %h", i, got_at(i), model_pix(i % c_W, i / c_W, sobel_thresh)); end
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_vertical_edge();
        test_thresh_zero();
        test_gapped();
        test_overrun();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
`default_nettype wire
